// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge
// Merges the core's instruction and data SRAM-style ports onto one shared
// memory port with an addr_ok/data_ok handshake. The core is stalled until
// every access requested in a cycle has completed; data goes before fetch.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   inst_*_i/_o         fetch request, address, registered fetched word
//   data_*_i/_o         data request, byte strobes, address, store data,
//                       registered load data
//   stall_o             core holds pipeline and request inputs while high
//   mem_*_o             shared memory request (valid, write, strobes,
//                       mapped address, write data)
//   mem_addr_ok_i       request accepted this cycle
//   mem_data_ok_i       read data / write response valid
//   mem_rdata_i         read data
//
// Parameter
//   MAP_KSEG            1: kseg0/kseg1 addresses are folded to physical
module cpu_mem_bridge #(
  parameter bit MAP_KSEG = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_rdata_o,
  input  logic        data_req_i,
  input  logic [3:0]  data_wen_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_addr_ok_i,
  input  logic        mem_data_ok_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        inst_pend_q, inst_pend_d;
  logic        data_pend_q, data_pend_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic [31:0] data_addr_q, data_addr_d;
  logic [3:0]  data_wen_q, data_wen_d;
  logic [31:0] data_wdata_q, data_wdata_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  function automatic logic [31:0] map_addr(input logic [31:0] a);
    if (MAP_KSEG && (a[31:30] == 2'b10)) return {3'b000, a[28:0]};
    return a;
  endfunction

  always_comb begin
    state_d      = state_q;
    inst_pend_d  = inst_pend_q;
    data_pend_d  = data_pend_q;
    inst_addr_d  = inst_addr_q;
    data_addr_d  = data_addr_q;
    data_wen_d   = data_wen_q;
    data_wdata_d = data_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    mem_req_o    = 1'b0;
    mem_wr_o     = 1'b0;
    mem_wstrb_o  = 4'b0000;
    mem_addr_o   = 32'h0;
    mem_wdata_o  = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (inst_req_i || data_req_i) begin
          inst_pend_d  = inst_req_i;
          data_pend_d  = data_req_i;
          inst_addr_d  = inst_addr_i;
          data_addr_d  = data_addr_i;
          data_wen_d   = data_wen_i;
          data_wdata_d = data_wdata_i;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        // Everything is driven from latched values, so the request is
        // stable for as long as the memory withholds addr_ok.
        mem_req_o = 1'b1;
        if (data_pend_q) begin
          mem_wr_o    = |data_wen_q;
          mem_wstrb_o = data_wen_q;
          mem_addr_o  = map_addr(data_addr_q);
          mem_wdata_o = data_wdata_q;
        end else begin
          mem_addr_o  = map_addr(inst_addr_q);
        end
        if (mem_addr_ok_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Data is always issued first, so a set data_pend means the
        // outstanding transaction is the data access.
        if (mem_data_ok_i) begin
          if (data_pend_q) begin
            if (data_wen_q == 4'b0000) data_rdata_d = mem_rdata_i;
            data_pend_d = 1'b0;
            state_d     = inst_pend_q ? S_REQ : S_DONE;
          end else begin
            inst_rdata_d = mem_rdata_i;
            inst_pend_d  = 1'b0;
            state_d      = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      inst_pend_q  <= 1'b0;
      data_pend_q  <= 1'b0;
      inst_addr_q  <= 32'h0;
      data_addr_q  <= 32'h0;
      data_wen_q   <= 4'b0000;
      data_wdata_q <= 32'h0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      inst_pend_q  <= inst_pend_d;
      data_pend_q  <= data_pend_d;
      inst_addr_q  <= inst_addr_d;
      data_addr_q  <= data_addr_d;
      data_wen_q   <= data_wen_d;
      data_wdata_q <= data_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // Stall rises in the request cycle itself so the core holds its inputs
  // before the bridge has even left IDLE.
  assign stall_o = ~rst_i & (((state_q == S_IDLE) & (inst_req_i | data_req_i))
                             | (state_q == S_REQ) | (state_q == S_WAIT));

  assign inst_rdata_o = inst_rdata_q;
  assign data_rdata_o = data_rdata_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
module tb_cpu_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_wen;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic        stall, mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] inst_rdata0, data_rdata0, mem_addr0, mem_wdata0;
  logic        stall0, mem_req0, mem_wr0;
  logic [3:0]  mem_wstrb0;

  always #5 clk = ~clk;

  cpu_mem_bridge #(.MAP_KSEG(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_rdata_o(inst_rdata),
    .data_req_i(data_req), .data_wen_i(data_wen), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .stall_o(stall),
    .mem_req_o(mem_req), .mem_wr_o(mem_wr), .mem_wstrb_o(mem_wstrb),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_addr_ok_i(mem_addr_ok), .mem_data_ok_i(mem_data_ok), .mem_rdata_i(mem_rdata));

  cpu_mem_bridge #(.MAP_KSEG(1'b0)) u_dut_nomap (
    .clk_i(clk), .rst_i(rst),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_rdata_o(inst_rdata0),
    .data_req_i(data_req), .data_wen_i(data_wen), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(data_rdata0), .stall_o(stall0),
    .mem_req_o(mem_req0), .mem_wr_o(mem_wr0), .mem_wstrb_o(mem_wstrb0),
    .mem_addr_o(mem_addr0), .mem_wdata_o(mem_wdata0),
    .mem_addr_ok_i(mem_addr_ok), .mem_data_ok_i(mem_data_ok), .mem_rdata_i(mem_rdata));

  typedef struct packed {
    logic [31:0] addr;
    logic        is_inst;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } acc_t;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  acc_t        acc [2];
  acc_t        cur;
  logic        chk_en = 1'b0;
  logic        chk_rd = 1'b0;
  logic        exp_stall = 1'b0;
  logic        exp_mreq = 1'b0;
  logic [31:0] m_inst = 32'h0;
  logic [31:0] m_data = 32'h0;
  int          hi_cnt = 0;
  logic [31:0] seen [$];
  logic [31:0] seen0 [$];

  function automatic logic [31:0] kmap(input logic [31:0] a);
    return (a[31:30] == 2'b10) ? (a & 32'h1FFF_FFFF) : a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("stall_nomap", 32'(stall0), 32'(exp_stall));
      chk("mem_req", 32'(mem_req), 32'(exp_mreq));
      chk("mem_req_nomap", 32'(mem_req0), 32'(exp_mreq));
      if (stall) hi_cnt++;
      if (exp_mreq) begin
        chk("mem_addr", mem_addr, kmap(cur.addr));
        chk("mem_addr_nomap", mem_addr0, cur.addr);
        chk("mem_wr", 32'(mem_wr), 32'(cur.wr));
        chk("mem_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
        if (cur.wr) chk("mem_wdata", mem_wdata, cur.wdata);
      end
      if (chk_rd) begin
        chk("inst_rdata", inst_rdata, m_inst);
        chk("data_rdata", data_rdata, m_data);
        chk("inst_rdata_nomap", inst_rdata0, m_inst);
        chk("data_rdata_nomap", data_rdata0, m_data);
      end
      if (mem_req && mem_addr_ok) seen.push_back(mem_addr);
      if (mem_req0 && mem_addr_ok) seen0.push_back(mem_addr0);
    end
  end

  // One core step: a cycle-accurate memory responder driven purely from the
  // handshake contract (addr_ok after ad wait cycles, data_ok dd cycles
  // after the cycle following acceptance). Step length follows from that.
  task automatic step(input logic ir, input logic [31:0] ia,
                      input logic dr, input logic [3:0] wen, input logic [31:0] da,
                      input logic [31:0] wd, input logic [31:0] ird, input logic [31:0] drd,
                      input int ad, input int dd, input logic spur);
    int n, len, nc;
    n = 0;
    if (dr) begin acc[n] = '{da, 1'b0, |wen, wen, wd, drd}; n++; end
    if (ir) begin acc[n] = '{ia, 1'b1, 1'b0, 4'b0000, 32'h0, ird}; n++; end
    len = 2 + ad + dd;
    nc  = 2 + n * len;
    seen.delete(); seen0.delete(); hi_cnt = 0;
    inst_req = ir; inst_addr = ia;
    data_req = dr; data_wen = wen; data_addr = da; data_wdata = wd;
    chk_en = 1'b1;
    for (int c = 0; c < nc; c++) begin
      int k, off;
      logic done_now;
      done_now = 1'b0; k = 0;
      exp_stall = (c != nc - 1);
      chk_rd = (c == nc - 1);
      exp_mreq = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = $urandom;
      if (c >= 1 && c < nc - 1) begin
        k = (c - 1) / len; off = (c - 1) % len;
        cur = acc[k];
        if (off <= ad) begin
          exp_mreq = 1'b1;
          mem_addr_ok = (off == ad);
          mem_data_ok = spur && (off < ad);
        end else if (off == len - 1) begin
          mem_data_ok = 1'b1; mem_rdata = acc[k].rdata; done_now = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (done_now) begin
        if (acc[k].is_inst) m_inst = acc[k].rdata;
        else if (!acc[k].wr) m_data = acc[k].rdata;
      end
    end
    inst_req = 1'b0; data_req = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    chk_en = 1'b0; chk_rd = 1'b0; exp_mreq = 1'b0;
  endtask

  // Quiet cycles with stray data_ok pulses that must be ignored.
  task automatic idle(input int cycles);
    chk_en = 1'b1; chk_rd = 1'b1; exp_stall = 1'b0; exp_mreq = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      mem_data_ok = c[0]; mem_rdata = $urandom;
      @(posedge clk); #1;
    end
    mem_data_ok = 1'b0; chk_en = 1'b0; chk_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wen = 4'b0; data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1; inst_req = 1'b1;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    @(posedge clk); #1;
    inst_req = 1'b0; rst = 1'b0;
    idle(2);

    // single fetch from kseg1
    step(1, 32'hBFC0_0000, 0, 4'b0, 32'h0, 32'h0, 32'h3C1D_0001, 32'h0, 0, 0, 0);
    chk("t1_nreq", 32'(seen.size()), 32'd1);
    if (seen.size() > 0) chk("t1_addr", seen[0], 32'h1FC0_0000);
    chk("t1_stall_cycles", 32'(hi_cnt), 32'd3);
    chk("t1_inst_rdata", inst_rdata, 32'h3C1D_0001);
    idle(3);

    // load + fetch in the same cycle: data first
    step(1, 32'hBFC0_0004, 1, 4'b0000, 32'h8000_1000, 32'h0,
         32'hAABB_CCDD, 32'h1234_5678, 0, 0, 0);
    chk("t2_nreq", 32'(seen.size()), 32'd2);
    if (seen.size() > 1) begin
      chk("t2_addr0", seen[0], 32'h0000_1000);
      chk("t2_addr1", seen[1], 32'h1FC0_0004);
    end
    chk("t2_stall_cycles", 32'(hi_cnt), 32'd5);
    chk("t2_data_rdata", data_rdata, 32'h1234_5678);
    chk("t2_inst_rdata", inst_rdata, 32'hAABB_CCDD);
    idle(1);

    // store: write response must not touch data_rdata
    step(0, 32'h0, 1, 4'b0011, 32'h8000_0200, 32'h0000_BEEF,
         32'h0, 32'hDEAD_BEEF, 0, 1, 0);
    chk("t3_data_rdata", data_rdata, 32'h1234_5678);
    chk("t3_stall_cycles", 32'(hi_cnt), 32'd4);

    // addr_ok withheld 3 cycles with stray data_ok in REQ
    step(1, 32'h0040_0000, 0, 4'b0, 32'h0, 32'h0, 32'h1111_2222, 32'h0, 3, 2, 1);
    chk("t4_stall_cycles", 32'(hi_cnt), 32'd8);
    chk("t4_inst_rdata", inst_rdata, 32'h1111_2222);
    idle(2);

    // kseg address through both mapping options
    step(0, 32'h0, 1, 4'b0000, 32'hA000_0010, 32'h0, 32'h0, 32'h5A5A_5A5A, 1, 0, 0);
    if (seen.size() > 0) chk("t5_addr_map", seen[0], 32'h0000_0010);
    if (seen0.size() > 0) chk("t5_addr_nomap", seen0[0], 32'hA000_0010);
    chk("t5_data_rdata", data_rdata, 32'h5A5A_5A5A);

    // reset while waiting for data_ok
    inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
    @(posedge clk); #1;
    mem_addr_ok = 1'b1;
    @(posedge clk); #1;
    mem_addr_ok = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("t6_stall_forced", 32'(stall), 32'h0);
    @(posedge clk); #1;
    inst_req = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("t6_mem_req", 32'(mem_req), 32'h0);
    chk("t6_mem_addr", mem_addr, 32'h0);
    chk("t6_inst_rdata", inst_rdata, 32'h0);
    chk("t6_data_rdata", data_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("t6_late_inst_rdata", inst_rdata, 32'h0);
    chk("t6_late_data_rdata", data_rdata, 32'h0);
    chk("t6_late_stall", 32'(stall), 32'h0);
    chk("t6_late_mem_req", 32'(mem_req), 32'h0);
    @(posedge clk); #1;
    m_inst = 32'h0; m_data = 32'h0;
    idle(2);

    // recovery: store + fetch with delays on both handshakes
    step(1, 32'h9FC0_0010, 1, 4'b1100, 32'h0000_0040, 32'hBEEF_0000,
         32'h0102_0304, 32'h7777_7777, 1, 1, 0);
    chk("t7_stall_cycles", 32'(hi_cnt), 32'd9);
    chk("t7_inst_rdata", inst_rdata, 32'h0102_0304);
    chk("t7_data_rdata", data_rdata, 32'h0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
